wb_grf: RTL

- Writeback-stage consumer of the MEM/WB pipeline register outputs (W_Instr, W_AO, W_RD, W_PC, W_A3).
- Selects the writeback data and commits it to the 32x32 general register file.
- Serves the two decode-stage read ports with internal W-to-D bypass.
- Emits a registered commit-trace record and a retired-instruction counter for the testbench and debug.

---
 rtl/wb_grf.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_grf.sv
// ============================================================================
// Module   : wb_grf
// Brief    : Writeback-stage data select, 32x32 register file with W-to-D
//            bypass, registered commit trace and retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_grf #(
    parameter logic [31:0] INITIAL_ADDRESS = 32'h0000_3000,
    parameter int          CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      W_Instr,
    input  logic [31:0]      W_AO,
    input  logic [31:0]      W_RD,
    input  logic [31:0]      W_PC,
    input  logic [4:0]       W_A3,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    output logic [31:0]      D_RD1,
    output logic [31:0]      D_RD2,
    output logic [31:0]      W_WD,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_a3,
    output logic [31:0]      trace_wd,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_LW      = 6'b100011;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_FN_JALR    = 6'b001001;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [31:0] w_link;
    logic        w_we;
    logic        w_retire;

    logic [31:0]      r_gpr [0:31];
    logic             r_trace_valid;
    logic [31:0]      r_trace_pc;
    logic [4:0]       r_trace_a3;
    logic [31:0]      r_trace_wd;
    logic [CNT_W-1:0] r_retire_cnt;

    assign w_opcode = W_Instr[31:26];
    assign w_funct  = W_Instr[5:0];
    // Link address wraps modulo 2^32; the carry out is intentionally dropped.
    assign w_link   = W_PC + 32'd8;
    assign w_we     = (W_A3 != 5'd0);
    assign w_retire = (W_Instr != 32'd0);

    always_comb begin
        W_WD = W_AO;
        if (w_opcode == c_OP_LW) begin
            W_WD = W_RD;
        end else if (w_opcode == c_OP_JAL) begin
            W_WD = w_link;
        end else if ((w_opcode == c_OP_SPECIAL) && (w_funct == c_FN_JALR)) begin
            W_WD = w_link;
        end
    end

    // Entry 0 is cleared at reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'd0;
            end
        end else if (w_we) begin
            r_gpr[W_A3] <= W_WD;
        end
    end

    // A write in flight this cycle is forwarded straight to decode.
    always_comb begin
        D_RD1 = r_gpr[D_A1];
        if (D_A1 == 5'd0) begin
            D_RD1 = 32'd0;
        end else if (D_A1 == W_A3) begin
            D_RD1 = W_WD;
        end
    end

    always_comb begin
        D_RD2 = r_gpr[D_A2];
        if (D_A2 == 5'd0) begin
            D_RD2 = 32'd0;
        end else if (D_A2 == W_A3) begin
            D_RD2 = W_WD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= INITIAL_ADDRESS;
            r_trace_a3    <= 5'd0;
            r_trace_wd    <= 32'd0;
        end else begin
            r_trace_valid <= w_we;
            if (w_we) begin
                r_trace_pc <= W_PC;
                r_trace_a3 <= W_A3;
                r_trace_wd <= W_WD;
            end
        end
    end

    // Counts every non-bubble instruction, including stores and branches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_a3    = r_trace_a3;
    assign trace_wd    = r_trace_wd;
    assign retire_cnt  = r_retire_cnt;

endmodule

`default_nettype wire
